lcd_id_strap_tx: RTL

Panel-side driver for the RGB LCD identification scheme.
- After reset it presents a 3-bit panel ID on the MSBs of the RGB565 bus (R7, G7, B7) for a fixed strap window. The host-side ID reader samples the bus during this window.
- It then releases the bus for a guard interval and switches to streaming pixel words through a valid/ready handshake.
- It is the testbench/panel model that sits opposite the host ID reader and pixel driver on the lcd_rgb bus.

---
 rtl/lcd_id_strap_tx_pkg.sv | 35 +++
 rtl/lcd_id_strap_tx_if.sv | 28 ++
 rtl/lcd_id_strap_tx.sv | 103 ++++++++++
 3 files changed

// File: rtl/lcd_id_strap_tx_pkg.sv
// Shared LCD identification definitions.
//   lcd_state_e  : panel driver FSM states
//   lcd_drive_t  : registered bus drive bundle (data, enable, strap_done)
//   LCD_*7_BIT   : lcd_rgb bit positions of the R/G/B MSBs used as ID straps
//   strap_word() : builds the strap word for a 3-bit panel ID. The host-side
//                  ID reader checks reuse it.
package lcd_pkg;

  typedef enum logic [1:0] {
    STRAP = 2'd0,
    GUARD = 2'd1,
    PIXEL = 2'd2
  } lcd_state_e;

  localparam int LCD_R7_BIT = 15;
  localparam int LCD_G7_BIT = 10;
  localparam int LCD_B7_BIT = 4;

  typedef struct packed {
    logic [15:0] rgb;
    logic        oe;
    logic        done;
  } lcd_drive_t;

  // id[0] -> R7, id[1] -> G7, id[2] -> B7; every other bit is low.
  function automatic logic [15:0] strap_word(input logic [2:0] id);
    logic [15:0] w;
    w             = 16'h0000;
    w[LCD_R7_BIT] = id[0];
    w[LCD_G7_BIT] = id[1];
    w[LCD_B7_BIT] = id[2];
    return w;
  endfunction

endpackage

// File: rtl/lcd_id_strap_tx_if.sv
// Panel-side LCD bus bundle.
//   restrap    : host -> panel, one-cycle request to re-enter the strap phase
//   pix_valid  : host -> panel, pixel word available
//   pix_data   : host -> panel, RGB565 pixel word
//   pix_ready  : panel -> host, pixel accepted this cycle
//   lcd_rgb    : panel -> bus, RGB565 drive value
//   lcd_rgb_oe : panel -> bus, output enable (0 = released)
//   strap_done : panel -> host, strap phase finished
// Modport master is the host/pixel-driver side; slave is the panel driver.
interface lcd_id_strap_tx_if;
  logic        restrap;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic [15:0] lcd_rgb;
  logic        lcd_rgb_oe;
  logic        strap_done;

  modport master (
    output restrap, pix_valid, pix_data,
    input  pix_ready, lcd_rgb, lcd_rgb_oe, strap_done
  );

  modport slave (
    input  restrap, pix_valid, pix_data,
    output pix_ready, lcd_rgb, lcd_rgb_oe, strap_done
  );
endinterface

// File: rtl/lcd_id_strap_tx.sv
// Panel-side RGB LCD ID strap driver.
// After reset, the block drives the panel ID on R7/G7/B7 for STRAP_CYCLES cycles.
// It then releases the bus for GUARD_CYCLES cycles and finally streams pixel
// words with a one-cycle latency and no buffering.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : lcd_id_strap_tx_if.slave (restrap, pixel handshake, lcd bus drive)
module lcd_id_strap_tx
  import lcd_pkg::*;
#(
  parameter logic [2:0] ID_CODE      = 3'b001,
  parameter int         STRAP_CYCLES = 16,
  parameter int         GUARD_CYCLES = 4,
  parameter int         CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  lcd_id_strap_tx_if.slave   bus
);

  localparam logic [15:0]      STRAP_W    = strap_word(ID_CODE);
  localparam logic [CNT_W-1:0] STRAP_LAST = CNT_W'(STRAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
  // With no guard interval, the strap phase hands straight over to PIXEL.
  localparam lcd_state_e       POST_STRAP = (GUARD_CYCLES == 0) ? PIXEL : GUARD;

  localparam lcd_drive_t DRV_STRAP = '{rgb: STRAP_W, oe: 1'b1, done: 1'b0};
  localparam lcd_drive_t DRV_GUARD = '{rgb: 16'h0000, oe: 1'b0, done: 1'b1};

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lcd_drive_t       drv_q, drv_d;
  logic             pix_ready;
  logic             accept;

  // Combinational ready: a restrap in the same cycle blocks the pixel.
  assign pix_ready = (state_q == PIXEL) && !bus.restrap;
  assign accept    = bus.pix_valid && pix_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.restrap) begin
      state_d = STRAP;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        STRAP: begin
          if (cnt_q == STRAP_LAST) begin
            state_d = POST_STRAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = PIXEL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PIXEL:   cnt_d = '0;
        default: begin
          state_d = STRAP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Bus drive is registered from the next state. This lets the outputs line up
  // with the state they describe. An accept only happens when state_d is PIXEL.
  always_comb begin
    drv_d = DRV_STRAP;
    unique case (state_d)
      STRAP:   drv_d = DRV_STRAP;
      GUARD:   drv_d = DRV_GUARD;
      PIXEL:   drv_d = '{rgb: accept ? bus.pix_data : 16'h0000, oe: 1'b1, done: 1'b1};
      default: drv_d = DRV_STRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STRAP;
      cnt_q   <= '0;
      drv_q   <= DRV_STRAP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.lcd_rgb    = drv_q.rgb;
  assign bus.lcd_rgb_oe = drv_q.oe;
  assign bus.strap_done = drv_q.done;

endmodule
